// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the pipeline datapath (drives decode/X/M/W info, consumes controls)
// slave : hazard_ctrl
interface hazard_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [REG_AW-1:0] d_rd;
    logic              d_rs_used;
    logic              d_rt_used;
    logic              d_we;
    logic              d_is_load;
    logic              d_is_md;
    logic              x_redirect;
    logic [DATA_W-1:0] x_a_rf;
    logic [DATA_W-1:0] x_b_rf;
    logic [DATA_W-1:0] m_result;
    logic [DATA_W-1:0] w_result;
    logic              stall_fd;
    logic              flush_fd;
    logic [DATA_W-1:0] x_opa;
    logic [DATA_W-1:0] x_opb;
    logic              md_busy;
    logic [31:0]       stall_count;

    modport master (
        output d_valid, d_rs, d_rt, d_rd, d_rs_used, d_rt_used, d_we,
               d_is_load, d_is_md, x_redirect, x_a_rf, x_b_rf,
               m_result, w_result,
        input  stall_fd, flush_fd, x_opa, x_opb, md_busy, stall_count
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rd, d_rs_used, d_rt_used, d_we,
               d_is_load, d_is_md, x_redirect, x_a_rf, x_b_rf,
               m_result, w_result,
        output stall_fd, flush_fd, x_opa, x_opb, md_busy, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, redirect flush,
// M/W operand bypass and a multi-cycle multdiv interlock.
// Optional build macro: HAZARD_PERF_EN adds a saturating stall-cycle counter;
// without it stall_count is tied to zero.
//
// Multdiv FSM
//   state   | meaning
//   MD_IDLE | no multdiv in flight
//   MD_BUSY | multdiv running, X held, decode stalled, down-counter active
//   MD_DONE | result ready; md entry leaves X for M this cycle
module hazard_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MD_LAT = 32
) (
    input  logic       clk_sys,
    input  logic       rst_b,
    hazard_ctrl_if.slave hz
);
    localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_t;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    stage_t    x_q, m_q, w_q;
    stage_t    x_d, m_d;
    md_state_t md_state, md_next;
    logic [7:0] md_cnt, md_cnt_d;

    logic busy;
    logic load_use;
    logic redirect_eff;
    logic stall;
    logic x_enter;
    logic m_hit_a, w_hit_a, m_hit_b, w_hit_b;

    // Hazard detection, stage advance and operand bypass
    always_comb begin
        busy         = (md_state == MD_BUSY);
        load_use     = x_q.valid && x_q.is_load && (x_q.rd != '0) &&
                       ((hz.d_rs_used && (hz.d_rs != '0) && (hz.d_rs == x_q.rd)) ||
                        (hz.d_rt_used && (hz.d_rt != '0) && (hz.d_rt == x_q.rd)));
        // X never holds a branch while it holds the multdiv, so a redirect
        // seen during BUSY is spurious and dropped.
        redirect_eff = hz.x_redirect && !busy;
        stall        = !redirect_eff && (load_use || busy);
        x_enter      = hz.d_valid && !stall && !redirect_eff;

        x_d = '0;
        if (busy) begin
            x_d = x_q;
        end else if (x_enter) begin
            x_d = '{valid: 1'b1, rs: hz.d_rs, rt: hz.d_rt, rd: hz.d_rd,
                    we: hz.d_we, is_load: hz.d_is_load};
        end
        m_d = busy ? '0 : x_q;

        m_hit_a = m_q.valid && m_q.we && (m_q.rd != '0) && (m_q.rd == x_q.rs);
        w_hit_a = w_q.valid && w_q.we && (w_q.rd != '0) && (w_q.rd == x_q.rs);
        m_hit_b = m_q.valid && m_q.we && (m_q.rd != '0) && (m_q.rd == x_q.rt);
        w_hit_b = w_q.valid && w_q.we && (w_q.rd != '0) && (w_q.rd == x_q.rt);

        hz.x_opa = hz.x_a_rf;
        if (m_hit_a)      hz.x_opa = hz.m_result;
        else if (w_hit_a) hz.x_opa = hz.w_result;

        hz.x_opb = hz.x_b_rf;
        if (m_hit_b)      hz.x_opb = hz.m_result;
        else if (w_hit_b) hz.x_opb = hz.w_result;

        hz.stall_fd = stall;
        hz.flush_fd = redirect_eff;
        hz.md_busy  = busy;
    end

    // Multdiv next state; a new md accepted during DONE restarts immediately
    always_comb begin
        md_next  = md_state;
        md_cnt_d = md_cnt;
        case (md_state)
            MD_IDLE, MD_DONE: begin
                if (x_enter && hz.d_is_md) begin
                    md_next  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end else begin
                    md_next  = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md_cnt == 8'd0) md_next = MD_DONE;
                else                md_cnt_d = md_cnt - 8'd1;
            end
            default: md_next = MD_IDLE;
        endcase
    end

    // Shadow pipeline and multdiv state registers
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            x_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            x_q      <= x_d;
            m_q      <= m_d;
            w_q      <= m_q;
            md_state <= md_next;
            md_cnt   <= md_cnt_d;
        end
    end

    // W only needs its destination for bypass; the rest rides along
    logic unused_w_fields;
    assign unused_w_fields = ^{w_q.rs, w_q.rt, w_q.is_load};

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of decode stall cycles
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign hz.stall_count = stall_cnt_q;
`else
    assign hz.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, reset-in-BUSY
// sequence, then randomized traffic against a behavioural pipeline model.
module tb_hazard_ctrl;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;

    localparam logic [31:0] A  = 32'h0000_0011;
    localparam logic [31:0] B  = 32'h0000_0022;
    localparam logic [31:0] MR = 32'h0000_0007;
    localparam logic [31:0] WR = 32'hDEAD_BEEF;

    logic clk_sys = 1'b0;
    logic rst_b   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    hazard_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) hz ();

    hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
        .clk_sys (clk_sys),
        .rst_b   (rst_b),
        .hz      (hz)
    );

    int n_total  = 0;
    int n_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit dv; int rs; int rt; int rd;
        bit ru; bit tu; bit we; bit ld; bit md; bit redir;
        logic [31:0] a; logic [31:0] b; logic [31:0] m; logic [31:0] w;
        bit e_stall; bit e_flush; bit e_busy;
        logic [31:0] e_opa; logic [31:0] e_opb;
    } vec_t;

    function automatic vec_t mk(bit dv, int rs, int rt, int rd, bit ru, bit tu, bit we,
                                bit ld, bit md, bit redir,
                                logic [31:0] a, logic [31:0] b, logic [31:0] m, logic [31:0] w,
                                bit es, bit ef, bit eb, logic [31:0] oa, logic [31:0] ob);
        vec_t v;
        v = '{dv, rs, rt, rd, ru, tu, we, ld, md, redir, a, b, m, w, es, ef, eb, oa, ob};
        return v;
    endfunction

    task automatic drive(bit dv, int rs, int rt, int rd, bit ru, bit tu, bit we, bit ld,
                         bit md, bit redir, logic [31:0] a, logic [31:0] b,
                         logic [31:0] m, logic [31:0] w);
        hz.d_valid    = dv;
        hz.d_rs       = REG_AW'(rs);
        hz.d_rt       = REG_AW'(rt);
        hz.d_rd       = REG_AW'(rd);
        hz.d_rs_used  = ru;
        hz.d_rt_used  = tu;
        hz.d_we       = we;
        hz.d_is_load  = ld;
        hz.d_is_md    = md;
        hz.x_redirect = redir;
        hz.x_a_rf     = a;
        hz.x_b_rf     = b;
        hz.m_result   = m;
        hz.w_result   = w;
    endtask

    // Behavioural model: instruction records per stage plus remaining md cycles
    typedef struct {bit v; int rs; int rt; int rd; bit we; bit ld;} ent_t;
    ent_t        mx, mm, mw;
    int          md_left;
    logic [31:0] m_scount;

    function automatic bit writes(ent_t e, int r);
        return e.v && e.we && (e.rd != 0) && (e.rd == r);
    endfunction

    function automatic logic [31:0] pick(ent_t sm, ent_t sw, int r, logic [31:0] rf,
                                         logic [31:0] m, logic [31:0] w);
        if (r == 0)         return rf;
        if (writes(sm, r))  return m;
        if (writes(sw, r))  return w;
        return rf;
    endfunction

    task automatic model_reset();
        mx = '{0, 0, 0, 0, 0, 0};
        mm = mx;
        mw = mx;
        md_left  = 0;
        m_scount = 0;
    endtask

    vec_t tbl[$];

    initial begin
        ent_t bub;
        bit   busy, lu, redir_eff, stall, enters;
        int   drs, drt;

        bub = '{0, 0, 0, 0, 0, 0};

        // ---------------- reset state ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 32'h5678, 32'h9, 32'hA);
        #12;
        chk("rst_stall", 32'(hz.stall_fd), 0);
        chk("rst_flush", 32'(hz.flush_fd), 0);
        chk("rst_busy",  32'(hz.md_busy), 0);
        chk("rst_count", hz.stall_count, 0);
        chk("rst_opa",   hz.x_opa, 32'h1234);
        chk("rst_opb",   hz.x_opb, 32'h5678);
        @(negedge clk_sys);
        rst_b = 1'b1;
        @(posedge clk_sys); #1;

        // ---------------- directed vector table ----------------
        //          dv rs rt rd ru tu we ld md rd  a  b  m  w   st fl bz opa opb
        tbl.push_back(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 3, 3, 4, 1, 1, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 6, 0, 5, 1, 0, 1, 1, 0, 0, A, B, MR, WR, 0, 0, 0, MR, MR));
        tbl.push_back(mk(1, 5, 0, 6, 1, 1, 1, 0, 0, 0, A, B, MR, WR, 1, 0, 0, A,  B));
        tbl.push_back(mk(1, 5, 0, 6, 1, 1, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 0, 0, 7, 1, 1, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, WR, B));
        tbl.push_back(mk(1, 1, 2, 0, 1, 1, 1, 0, 0, 0, A, B, 5,  WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 1, 2, 0, 1, 1, 1, 0, 0, 0, A, B, 5,  WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 0, 0, 8, 1, 1, 1, 0, 0, 0, A, B, 5,  5,  0, 0, 0, A,  B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5,  5,  0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 1, 0, 9, 1, 0, 1, 1, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 9, 9, 10,1, 1, 1, 0, 0, 1, A, B, MR, WR, 0, 1, 0, A,  B));
        tbl.push_back(mk(1, 9, 9, 10,1, 1, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(1, 1, 2, 11,1, 1, 1, 0, 1, 0, A, B, MR, WR, 0, 0, 0, WR, WR));
        tbl.push_back(mk(1, 11,0, 12,1, 0, 1, 0, 0, 0, A, B, MR, WR, 1, 0, 1, A,  B));
        tbl.push_back(mk(1, 11,0, 12,1, 0, 1, 0, 0, 1, A, B, MR, WR, 1, 0, 1, A,  B));
        tbl.push_back(mk(1, 11,0, 12,1, 0, 1, 0, 0, 0, A, B, MR, WR, 1, 0, 1, A,  B));
        tbl.push_back(mk(1, 11,0, 12,1, 0, 1, 0, 0, 0, A, B, MR, WR, 1, 0, 1, A,  B));
        tbl.push_back(mk(1, 11,0, 12,1, 0, 1, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A, B, MR, WR, 0, 0, 0, MR, B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A, B, MR, WR, 0, 0, 0, A,  B));

        foreach (tbl[i]) begin
            drive(tbl[i].dv, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].ru, tbl[i].tu,
                  tbl[i].we, tbl[i].ld, tbl[i].md, tbl[i].redir,
                  tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].w);
            @(negedge clk_sys);
            chk($sformatf("vec%0d_stall", i), 32'(hz.stall_fd), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(hz.flush_fd), 32'(tbl[i].e_flush));
            chk($sformatf("vec%0d_busy",  i), 32'(hz.md_busy),  32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_opa",   i), hz.x_opa, tbl[i].e_opa);
            chk($sformatf("vec%0d_opb",   i), hz.x_opb, tbl[i].e_opb);
            @(posedge clk_sys); #1;
        end
`ifdef HAZARD_PERF_EN
        chk("tbl_stall_count", hz.stall_count, 32'd5);
`else
        chk("tbl_stall_count", hz.stall_count, 32'd0);
`endif

        // ---------------- reset during BUSY cycle 2 ----------------
        drive(1, 1, 2, 13, 1, 1, 1, 0, 1, 0, A, B, MR, WR);
        @(posedge clk_sys); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A, B, MR, WR);
        chk("md_busy_c1", 32'(hz.md_busy), 1);
        @(posedge clk_sys); #2;
        chk("md_busy_c2", 32'(hz.md_busy), 1);
        rst_b = 1'b0;
        #1;
        chk("rst_mid_busy",  32'(hz.md_busy), 0);
        chk("rst_mid_stall", 32'(hz.stall_fd), 0);
        chk("rst_mid_count", hz.stall_count, 0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        @(posedge clk_sys); #1;
        chk("post_rst_busy",  32'(hz.md_busy), 0);
        chk("post_rst_stall", 32'(hz.stall_fd), 0);
        chk("post_rst_opa",   hz.x_opa, A);

        // ---------------- randomized traffic vs model ----------------
        rst_b = 1'b0;
        #3;
        model_reset();
        @(negedge clk_sys);
        rst_b = 1'b1;
        @(posedge clk_sys); #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit md_r;
            md_r = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, !md_r && ($urandom_range(0, 2) == 0), md_r,
                  $urandom_range(0, 9) == 0, $urandom, $urandom, $urandom, $urandom);
            @(negedge clk_sys);
            drs = int'(hz.d_rs);
            drt = int'(hz.d_rt);
            busy      = (md_left > 0);
            lu        = mx.v && mx.ld && (mx.rd != 0) &&
                        ((hz.d_rs_used && drs != 0 && drs == mx.rd) ||
                         (hz.d_rt_used && drt != 0 && drt == mx.rd));
            redir_eff = hz.x_redirect && !busy;
            stall     = !redir_eff && (busy || lu);
            chk("rnd_stall", 32'(hz.stall_fd), 32'(stall));
            chk("rnd_flush", 32'(hz.flush_fd), 32'(redir_eff));
            chk("rnd_busy",  32'(hz.md_busy),  32'(busy));
            chk("rnd_opa", hz.x_opa, pick(mm, mw, mx.rs, hz.x_a_rf, hz.m_result, hz.w_result));
            chk("rnd_opb", hz.x_opb, pick(mm, mw, mx.rt, hz.x_b_rf, hz.m_result, hz.w_result));
`ifdef HAZARD_PERF_EN
            chk("rnd_count", hz.stall_count, m_scount);
            if (stall && m_scount != 32'hFFFF_FFFF) m_scount = m_scount + 1;
`else
            chk("rnd_count", hz.stall_count, 0);
`endif
            enters = hz.d_valid && !stall && !redir_eff;
            mw = mm;
            if (busy) begin
                mm = bub;
                md_left = md_left - 1;
            end else begin
                mm = mx;
                if (enters) begin
                    mx = '{1, drs, drt, int'(hz.d_rd), hz.d_we, hz.d_is_load};
                    if (hz.d_is_md) md_left = MD_LAT;
                end else begin
                    mx = bub;
                end
            end
            @(posedge clk_sys); #1;
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand/result data width.
REQ-002 Parameter REG_AW, default 5, register-index width; register 0 is hardwired zero.
REQ-003 Parameter MD_LAT, default 32, multdiv busy cycles, legal range 2..255.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-006 d_valid  in  1  decode-stage instruction present.
REQ-007 d_rs, d_rt, d_rd  in  REG_AW each  decode source/dest indices.
REQ-008 d_rs_used, d_rt_used, d_we, d_is_load, d_is_md  in  1 each  decode-stage usage/class flags.
REQ-009 x_redirect  in  1  branch/jump resolved taken in X.
REQ-010 x_a_rf, x_b_rf  in  DATA_W each  X-stage operands as read from the register file.
REQ-011 m_result, w_result  in  DATA_W each  M-stage ALU result, W-stage writeback value.
REQ-012 stall_fd  out  1  hold PC and FD register.
REQ-013 flush_fd  out  1  squash FD contents.
REQ-014 x_opa, x_opb  out  DATA_W each  bypassed X-stage operands.
REQ-015 md_busy  out  1  multdiv in progress.
REQ-016 stall_count  out  32  stall-cycle counter (REQ-033).

Function
REQ-017 Block SHALL keep shadow stages X, M, W, each holding valid, rs, rt, rd, we, is_load; each cycle X->M->W advance unconditionally.
REQ-018 Decode fields SHALL enter X when d_valid=1, stall_fd=0, x_redirect=0; otherwise X receives a bubble (valid=0).
REQ-019 A stage SHALL be a write hazard source only if valid=1, we=1, rd!=0.
REQ-020 Load-use: stall_fd SHALL be 1 when X is a valid load with rd!=0 matching a used, nonzero d_rs or d_rt.
REQ-021 Bypass priority for x_opa (rs) and x_opb (rt): M match -> m_result; else W match -> w_result; else register-file value; index 0 always yields the register-file value.
REQ-022 M-stage load match SHALL NOT occur (prevented by REQ-020); W load supplies w_result.
REQ-023 Multdiv FSM states IDLE, BUSY, DONE; IDLE->BUSY when valid md instruction enters X, counter loads MD_LAT-1.
REQ-024 BUSY: counter decrements each cycle; at 0 -> DONE; md_busy=1 in BUSY only.
REQ-025 DONE lasts exactly one cycle, then IDLE; md instruction's shadow entry advances into M on DONE.
REQ-026 While BUSY, stall_fd SHALL be 1 and X SHALL hold its md entry (M receives bubbles).
REQ-027 Redirect SHALL dominate stall: flush_fd=1, X bubble, stall_fd forced 0, same cycle.
REQ-028 x_redirect during BUSY SHALL be ignored (redirects cannot originate while X holds md).
REQ-029 stall_fd and flush_fd combinational from current state and inputs; operand latency 0 cycles.

Reset
REQ-030 On reset low: all stage valid=0, FSM=IDLE, counter=0, stall_count=0; stall_fd=0, flush_fd=0, md_busy=0.
REQ-031 Reset mid-BUSY SHALL abandon the operation; first cycle after release is IDLE with no stall.
REQ-032 x_opa/x_opb after reset equal x_a_rf/x_b_rf.

Configuration
REQ-033 Macro HAZARD_PERF_EN defined: stall_count increments each cycle stall_fd=1, saturates at 32'hFFFF_FFFF; undefined: stall_count tied to 0, no counter flops.

Verification
REQ-034 X=add r3, decode=add r4,r3,r3 -> x_opa sourced from m_result one cycle later; m_result=0x0000_0007 -> x_opa=7, x_opb=7.
REQ-035 X=lw r5, decode reads r5 -> stall_fd=1 one cycle, X bubble, then W bypass gives w_result=0xDEAD_BEEF on x_opa.
REQ-036 Writes to r0 in M and W with m_result=5 -> operand reading r0 returns x_a_rf=0, no stall.
REQ-037 md enters X, MD_LAT=4 -> md_busy=1 for 4 cycles, stall_fd=1 for those cycles, DONE one cycle, IDLE.
REQ-038 Load-use stall and x_redirect same cycle -> flush_fd=1, stall_fd=0; reset low during BUSY cycle 2 -> md_busy=0 immediately, stall_count=0.
